data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 2, meaning set-index width (2**INDEX_W sets, 2 ways, one 32-bit word per line).
REQ-002 SHALL have port clk, input, 1, the single clock; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ce_i, input, 1, MEM request valid.
REQ-005 SHALL have port we_i, input, 1, request is a store.
REQ-006 SHALL have port addr_i, input, 32, byte address; addr_i[1:0] ignored.
REQ-007 SHALL have port sel_i, input, 4, store byte enables; ignored for loads.
REQ-008 SHALL have port data_i, input, 32, store data.
REQ-009 SHALL have port flush_i, input, 1, invalidate whole cache.
REQ-010 SHALL have port mem_data_o, output, 32, load data to MEM.
REQ-011 SHALL have port stall_o, output, 1, request not yet complete; MEM holds all inputs while high.
REQ-012 SHALL have ports ram_ce_o/ram_we_o (1), ram_addr_o (32), ram_sel_o (4), ram_data_o (32), outputs, RAM request.
REQ-013 SHALL have ports ram_data_i (32) and ram_ack_i (1), inputs, RAM read data and completion strobe.

Function
REQ-014 Address split SHALL be index = addr_i[INDEX_W+1:2], tag = addr_i[31:INDEX_W+2]; line = valid bit + tag + 32-bit data.
REQ-015 Hit in way w SHALL mean valid[w][index] and tag[w][index] == tag; at most one way hits.
REQ-016 States SHALL be IDLE, REFILL, WRITE, RESP.
REQ-017 IDLE, ce_i=0 and flush_i=0: stall_o=0, mem_data_o=0, RAM outputs 0.
REQ-018 IDLE, flush_i=1 (priority over ce_i): all valid and LRU bits cleared at next edge, stall_o=1, stay IDLE; request is retried next cycle.
REQ-019 IDLE, load hit: mem_data_o = hit-way data combinationally, stall_o=0, LRU[index] points to the other way at next edge, stay IDLE (zero-stall).
REQ-020 IDLE, load miss: stall_o=1, go to REFILL.
REQ-021 REFILL: ram_ce_o=1, ram_we_o=0, ram_sel_o=4'hF, ram_addr_o={addr_i[31:2],2'b00}, stall_o=1 until ram_ack_i.
REQ-022 REFILL with ram_ack_i: victim = invalid way (way0 if both invalid) else way LRU[index]; victim gets tag, ram_data_i, valid=1; LRU points to other way; ram_data_i latched; go to RESP.
REQ-023 IDLE, store (hit or miss): stall_o=1, go to WRITE; on a hit, bytes with sel_i[k]=1 of the hit line are updated from data_i and LRU updated at that edge; a miss does not allocate.
REQ-024 WRITE: ram_ce_o=1, ram_we_o=1, ram_addr_o={addr_i[31:2],2'b00}, ram_sel_o=sel_i, ram_data_o=data_i, stall_o=1 until ram_ack_i, then go to RESP (write-through).
REQ-025 RESP: stall_o=0, RAM outputs 0, mem_data_o = latched refill data for loads, 0 for stores; next state IDLE unconditionally; held request is not re-executed.
REQ-026 Load-miss latency SHALL be ack cycle + 1 (data in RESP); store latency ack cycle + 1.
REQ-027 flush_i outside IDLE SHALL be ignored; caller holds it until stall_o=0.
REQ-028 ram_ack_i in IDLE or RESP SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear all valid and LRU bits, and drive every output to 0 (stall_o=0, ram_ce_o=0).
REQ-030 Reset during REFILL/WRITE SHALL abandon the RAM transaction (ram_ce_o drops asynchronously) with no line written.
REQ-031 Tag/data arrays need no reset; only valid bits gate hits.

Verification
REQ-032 Load 0x00000010 after reset, ack after 3 cycles with 0xDEADBEEF -> stall_o high 4 cycles, RESP gives 0xDEADBEEF; repeat load -> same-cycle hit, stall_o=0, no ram_ce_o.
REQ-033 Fill 0x10 and 0x50 (same index, INDEX_W=2), read 0x10, then load 0x90 -> victim is way holding 0x50; load 0x10 still hits.
REQ-034 Store 0x000000AB sel_i=4'b0001 to cached 0x10 (0xDEADBEEF) -> ram_we_o=1, ram_sel_o=4'b0001; subsequent load hits 0xDEADBEAB.
REQ-035 Store miss to 0x20 -> RAM write issued; following load 0x20 misses (no allocate).
REQ-036 flush_i=1 with ce_i=1 in IDLE -> stall_o=1 one cycle; next-cycle load of 0x10 misses.
REQ-037 rst asserted mid-REFILL -> ram_ce_o=0 and stall_o=0 immediately; after release load of that address misses.

Source files
------------

// File: rtl/data_cache.sv
// Two-way set-associative, write-through, no-write-allocate data cache with one
// 32-bit word per line and a single-outstanding-request RAM port.
module data_cache #(
  parameter int unsigned INDEX_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] mem_data_o,
  output logic        stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i
);

  localparam int unsigned SETS  = 1 << INDEX_W;
  localparam int unsigned TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  state_t             r_state, w_next;
  logic [SETS-1:0]    r_valid0, r_valid1, r_lru;
  logic [TAG_W-1:0]   r_tag0  [SETS];
  logic [TAG_W-1:0]   r_tag1  [SETS];
  logic [31:0]        r_data0 [SETS];
  logic [31:0]        r_data1 [SETS];
  logic [31:0]        r_rdata;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_addr;
  logic               w_hit0, w_hit1, w_hit, w_victim;
  logic               w_idle_act, w_ld_hit, w_st_hit, w_fill, w_flush;

  assign w_idx  = addr_i[INDEX_W+1:2];
  assign w_tag  = addr_i[31:INDEX_W+2];
  assign w_addr = addr_i & 32'hFFFF_FFFC;

  assign w_hit0 = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1 = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;

  // Prefer an empty way; only consult LRU when both ways are occupied.
  assign w_victim = !r_valid0[w_idx] ? 1'b0 :
                    !r_valid1[w_idx] ? 1'b1 : r_lru[w_idx];

  assign w_flush    = (r_state == IDLE) && flush_i;
  assign w_idle_act = (r_state == IDLE) && !flush_i && ce_i;
  assign w_ld_hit   = w_idle_act && !we_i && w_hit;
  assign w_st_hit   = w_idle_act && we_i && w_hit;
  assign w_fill     = (r_state == REFILL) && ram_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!flush_i && ce_i) begin
          if (we_i)        w_next = WRITE;
          else if (!w_hit) w_next = REFILL;
        end
      end
      REFILL:  if (ram_ack_i) w_next = RESP;
      WRITE:   if (ram_ack_i) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_data_o = '0;
    stall_o    = 1'b0;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (flush_i) begin
            stall_o = 1'b1;
          end else if (ce_i) begin
            if (we_i || !w_hit) stall_o = 1'b1;
            else mem_data_o = w_hit0 ? r_data0[w_idx] : r_data1[w_idx];
          end
        end
        REFILL: begin
          stall_o    = 1'b1;
          ram_ce_o   = 1'b1;
          ram_sel_o  = 4'hF;
          ram_addr_o = w_addr;
        end
        WRITE: begin
          stall_o    = 1'b1;
          ram_ce_o   = 1'b1;
          ram_we_o   = 1'b1;
          ram_sel_o  = sel_i;
          ram_data_o = data_i;
          ram_addr_o = w_addr;
        end
        RESP:    mem_data_o = r_rdata;
        default: ;
      endcase
    end
  end

  // LRU bit names the way to evict next; touching a way points it at the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
      r_rdata  <= '0;
    end else if (w_flush) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (w_ld_hit || w_st_hit) r_lru[w_idx] <= w_hit0;
      if (w_idle_act && we_i)   r_rdata <= '0;
      if (w_fill) begin
        if (w_victim) r_valid1[w_idx] <= 1'b1;
        else          r_valid0[w_idx] <= 1'b1;
        r_lru[w_idx] <= ~w_victim;
        r_rdata      <= ram_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (w_victim) begin
        r_tag1[w_idx]  <= w_tag;
        r_data1[w_idx] <= ram_data_i;
      end else begin
        r_tag0[w_idx]  <= w_tag;
        r_data0[w_idx] <= ram_data_i;
      end
    end
    if (w_st_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (sel_i[k]) begin
          if (w_hit0) r_data0[w_idx][8*k +: 8] <= data_i[8*k +: 8];
          else        r_data1[w_idx][8*k +: 8] <= data_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: driver pushes expected responses, a negedge
// monitor pops and checks them whenever a held request completes.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] mem_data_o;
  logic        stall_o, ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_i = '0;
  logic        ram_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  data_cache #(.INDEX_W(2)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .flush_i(flush_i),
    .mem_data_o(mem_data_o), .stall_o(stall_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          stalls;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor state, observed per outstanding request.
  int          m_stalls = 0;
  logic        m_ce = 1'b0, m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_stalls = 0; m_ce = 1'b0; m_we = 1'b0;
    end else if (ce_i) begin
      if (ram_ce_o) begin
        m_ce = 1'b1;
        m_sel = ram_sel_o;
        m_addr = ram_addr_o;
        if (ram_we_o) begin
          m_we = 1'b1;
          m_wdata = ram_data_o;
        end
      end
      if (stall_o) begin
        m_stalls++;
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got data %h with no request pending", mem_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".data"}, mem_data_o, e.data);
        chk({e.name, ".stalls"}, 32'(m_stalls), 32'(e.stalls));
        chk({e.name, ".ram_ce"}, {31'd0, m_ce}, {31'd0, e.ce});
        if (e.ce) begin
          chk({e.name, ".ram_we"}, {31'd0, m_we}, {31'd0, e.we});
          chk({e.name, ".ram_sel"}, {28'd0, m_sel}, {28'd0, e.sel});
          chk({e.name, ".ram_addr"}, m_addr, e.addr);
          if (e.we) chk({e.name, ".ram_wdata"}, m_wdata, e.wdata);
        end
        m_stalls = 0; m_ce = 1'b0; m_we = 1'b0;
      end
    end
  end

  task automatic req(input string nm, input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int ackdly,
                     input logic [31:0] exp_data, input int exp_stalls,
                     input logic exp_ce, input logic fl);
    exp_t e;
    int   n;
    bit   done;
    e.name = nm; e.data = exp_data; e.stalls = exp_stalls; e.ce = exp_ce;
    e.we = we; e.sel = we ? sel : 4'hF; e.addr = addr & 32'hFFFF_FFFC; e.wdata = wdata;
    exp_q.push_back(e);
    n = 0; done = 1'b0;
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = wdata; flush_i = fl;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      if (ram_ce_o) begin
        n++;
        ram_ack_i = (n == ackdly);
        ram_data_i = rdata;
      end
      @(posedge clk); #1;
      ram_ack_i = 1'b0;
      flush_i = 1'b0;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: stall_o still high after 40 cycles, expected completion", nm);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b0; flush_i = 1'b0; ram_ack_i = 1'b0;
  endtask

  initial begin
    // Outputs must be forced low while reset is held, even with a missing request present.
    ce_i = 1'b1; addr_i = 32'h10;
    #12;
    chk("reset.stall", {31'd0, stall_o}, 32'd0);
    chk("reset.ram_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("reset.mem_data", mem_data_o, 32'd0);
    ce_i = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    //   name            we    addr          sel    wdata          rdata          ack exp_data       stl ce  fl
    req("ld10_miss",    1'b0, 32'h10, 4'h0, 32'h0,         32'hDEADBEEF, 3, 32'hDEADBEEF, 4, 1'b1, 1'b0);
    req("ld10_hit",     1'b0, 32'h12, 4'h0, 32'h0,         32'h0,        1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    req("ld50_miss",    1'b0, 32'h50, 4'h0, 32'h0,         32'h55555555, 1, 32'h55555555, 2, 1'b1, 1'b0);
    req("ld10_hit2",    1'b0, 32'h10, 4'h0, 32'h0,         32'h0,        1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    req("ld90_miss",    1'b0, 32'h90, 4'h0, 32'h0,         32'h99999999, 2, 32'h99999999, 3, 1'b1, 1'b0);
    req("ld10_hit3",    1'b0, 32'h10, 4'h0, 32'h0,         32'h0,        1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    req("ld90_hit",     1'b0, 32'h90, 4'h0, 32'h0,         32'h0,        1, 32'h99999999, 0, 1'b0, 1'b0);
    req("st10_hit",     1'b1, 32'h10, 4'h1, 32'h000000AB,  32'h0,        2, 32'h0,        3, 1'b1, 1'b0);
    req("ld10_merged",  1'b0, 32'h10, 4'h0, 32'h0,         32'h0,        1, 32'hDEADBEAB, 0, 1'b0, 1'b0);
    req("st20_miss",    1'b1, 32'h20, 4'hF, 32'h12345678,  32'h0,        1, 32'h0,        2, 1'b1, 1'b0);
    req("ld20_noalloc", 1'b0, 32'h20, 4'h0, 32'h0,         32'h12345678, 1, 32'h12345678, 2, 1'b1, 1'b0);
    req("ld50_evicted", 1'b0, 32'h50, 4'h0, 32'h0,         32'h55555555, 1, 32'h55555555, 2, 1'b1, 1'b0);
    req("ld20_hit",     1'b0, 32'h20, 4'h0, 32'h0,         32'h0,        1, 32'h12345678, 0, 1'b0, 1'b0);
    req("flush_ld10",   1'b0, 32'h10, 4'h0, 32'h0,         32'hDEADBEAB, 1, 32'hDEADBEAB, 3, 1'b1, 1'b1);
    req("ld10_postfl",  1'b0, 32'h10, 4'h0, 32'h0,         32'h0,        1, 32'hDEADBEAB, 0, 1'b0, 1'b0);

    // Abandon a refill with reset and confirm the RAM request drops at once.
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'hC0;
    @(negedge clk);
    @(negedge clk);
    chk("midrefill.ram_ce", {31'd0, ram_ce_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrefill.rst_ram_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("midrefill.rst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    req("ldC0_miss",    1'b0, 32'hC0, 4'h0, 32'h0,         32'hC0C0C0C0, 1, 32'hC0C0C0C0, 2, 1'b1, 1'b0);
    req("ld10_rstmiss", 1'b0, 32'h10, 4'h0, 32'h0,         32'h01010101, 1, 32'h01010101, 2, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
